fpu_result_fifo: RTL and testbench
==================================

FPU_RESULT_FIFO -- requirements
Module: fpu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries (power of 2, >=2).
REQ-002 SHALL have parameter AFULL_LVL, default 3, occupancy at which almost_full asserts.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  multiplier result valid this cycle.
REQ-006 SHALL have port in_Sz  input  1  result sign from multiplier.
REQ-007 SHALL have port in_Ez  input  8  result exponent from multiplier.
REQ-008 SHALL have port in_Mz  input  23  result mantissa from multiplier.
REQ-009 SHALL have port in_flags  input  5  {invalid, overflow, underflow, inexact, zero} flags from multiplier.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port out_data  output  32  head result {Sz,Ez,Mz}.
REQ-013 SHALL have port out_flags  output  5  head entry flags, same order as in_flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port full  output  1  count == DEPTH.
REQ-016 SHALL have port almost_full  output  1  count >= AFULL_LVL; upstream stops issuing operands.
REQ-017 SHALL have port sticky_flags  output  5  IEEE status: OR of flags of all accepted results since last clear.
REQ-018 SHALL have port sticky_clr  input  1  synchronous clear of sticky_flags and drop_err.
REQ-019 SHALL have port drop_err  output  1  sticky: a result was discarded because the FIFO was full.

Function
REQ-020 SHALL store each entry as 37 bits {Sz,Ez,Mz,flags} in a DEPTH-entry circular buffer with write and read pointers wrapping modulo DEPTH.
REQ-021 SHALL be first-word-fall-through: out_valid = (count != 0); out_data/out_flags driven from the read-pointer entry with no extra cycle.
REQ-022 SHALL pop (advance read pointer, count-1) when out_valid && out_ready; out_ready with count==0 has no effect.
REQ-023 SHALL push (write entry, advance write pointer, count+1) when in_valid && (count < DEPTH).
REQ-024 SHALL, when in_valid && full && pop in the same cycle, accept the push; count stays DEPTH.
REQ-025 SHALL, when push and pop occur in the same cycle at any occupancy, leave count unchanged and move both pointers.
REQ-026 SHALL, when in_valid && full && no pop, discard the input, leave storage/pointers/count unchanged, set drop_err.
REQ-027 SHALL, on empty push, present the new entry on out_data with out_valid high the cycle after the push edge (latency 1).
REQ-028 SHALL update sticky_flags <= sticky_flags | in_flags on every accepted push; dropped inputs do not update it.
REQ-029 SHALL, on sticky_clr, load sticky_flags <= (accepted push ? in_flags : 0) and drop_err <= (drop this cycle ? 1 : 0).
REQ-030 SHALL track occupancy state EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); transitions only by +/-1 or hold per REQ-022..026.
REQ-031 SHALL keep full and almost_full as registered-state decodes of count (no combinational path from in_valid/out_ready).
REQ-032 SHALL not modify result bits; entries are returned exactly as pushed, in push order.

Reset
REQ-033 SHALL, on RST low, asynchronously clear pointers, count, sticky_flags, drop_err and all storage to 0; out_valid=0, out_data=0, out_flags=0, full=0, almost_full=0.
REQ-034 SHALL discard all queued entries if reset asserts mid-operation; no pop or push is performed during reset.

Verification
REQ-035 Push 0x40000000 flags 00000 into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_data=0x40000000, count=1.
REQ-036 Push 4 results (0x3F800000, 0x40400000, 0x7F800000 flags 01010, 0x00000000 flags 00001) with out_ready=0 -> full=1, almost_full=1 at count 3, sticky_flags=01011; popping returns the 4 in order.
REQ-037 FIFO full, in_valid=1 value 0x41200000, out_ready=0 -> input dropped, drop_err=1, count=4; repeat with out_ready=1 -> accepted, count=4, 0x41200000 last out.
REQ-038 Continuous in_valid and out_ready=1 for 10 cycles -> count stays 1 after first push, pointers wrap twice, output order matches input.
REQ-039 sticky_clr with simultaneous push of flags 10000 -> sticky_flags=10000, drop_err=0.
REQ-040 RST low while count=3 -> out_valid=0, count=0, sticky_flags=0 immediately, before next CLK edge.

Source files
------------

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - first-word-fall-through result FIFO for the FPU multiplier with sticky IEEE status
module fpu_result_fifo #(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    input  logic                       in_Sz,
    input  logic [7:0]                 in_Ez,
    input  logic [22:0]                in_Mz,
    input  logic [4:0]                 in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [4:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       almost_full,
    output logic [4:0]                 sticky_flags,
    input  logic                       sticky_clr,
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } occ_t;

    occ_t          state;
    occ_t          state_next;
    logic [CW-1:0] count_next;
    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          drop;

    // A full FIFO still accepts a new result when the head leaves in the same cycle.
    assign pop  = (state != ST_EMPTY) && out_ready;
    assign push = in_valid && ((state != ST_FULL) || pop);
    assign drop = in_valid && (state == ST_FULL) && !pop;

    always_comb begin
        count_next = count;
        state_next = state;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next == DEPTH_C) begin
            state_next = ST_FULL;
        end else begin
            state_next = ST_PARTIAL;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_EMPTY;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) begin
                mem[wptr] <= {in_Sz, in_Ez, in_Mz, in_flags};
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Clear wins over accumulation, but an event in the clearing cycle is still recorded.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sticky_flags <= '0;
            drop_err     <= 1'b0;
        end else if (sticky_clr) begin
            sticky_flags <= push ? in_flags : 5'b0;
            drop_err     <= drop;
        end else begin
            if (push) begin
                sticky_flags <= sticky_flags | in_flags;
            end
            if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    assign out_valid   = (state != ST_EMPTY);
    assign out_data    = mem[rptr][36:5];
    assign out_flags   = mem[rptr][4:0];
    assign full        = (state == ST_FULL);
    assign almost_full = (count >= AFULL_C);

endmodule

// File: tb/tb_fpu_result_fifo.sv
// tb/tb_fpu_result_fifo.sv - scoreboard bench for fpu_result_fifo
module tb_fpu_result_fifo;

    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 3;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_Sz;
    logic [7:0]  in_Ez;
    logic [22:0] in_Mz;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic [2:0]  count;
    logic        full;
    logic        almost_full;
    logic [4:0]  sticky_flags;
    logic        sticky_clr;
    logic        drop_err;

    int          checks;
    int          errors;
    logic [36:0] sb [$];
    logic [4:0]  m_sticky;
    logic        m_drop;

    fpu_result_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_Sz        (in_Sz),
        .in_Ez        (in_Ez),
        .in_Mz        (in_Mz),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .drop_err     (drop_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [36:0] head;
        check("count", 64'(count), 64'(sb.size()));
        check("full", 64'(full), 64'(sb.size() == DEPTH));
        check("almost_full", 64'(almost_full), 64'(sb.size() >= AFULL_LVL));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("sticky_flags", 64'(sticky_flags), 64'(m_sticky));
        check("drop_err", 64'(drop_err), 64'(m_drop));
        if (sb.size() != 0) begin
            head = sb[0];
            check("head_data", 64'(out_data), 64'(head[36:5]));
            check("head_flags", 64'(out_flags), 64'(head[4:0]));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] f,
                         input logic r, input logic c);
        logic        pop_m;
        logic        push_m;
        logic        drop_now;
        logic [36:0] head;
        in_valid   = v;
        in_Sz      = d[31];
        in_Ez      = d[30:23];
        in_Mz      = d[22:0];
        in_flags   = f;
        out_ready  = r;
        sticky_clr = c;
        #2;
        pop_m    = r && (sb.size() != 0);
        push_m   = v && ((sb.size() < DEPTH) || pop_m);
        drop_now = v && !push_m;
        if (pop_m) begin
            head = sb.pop_front();
            check("pop_valid", 64'(out_valid), 64'd1);
            check("pop_data", 64'(out_data), 64'(head[36:5]));
            check("pop_flags", 64'(out_flags), 64'(head[4:0]));
        end
        if (push_m) sb.push_back({d, f});
        if (c) begin
            m_sticky = push_m ? f : 5'b0;
            m_drop   = drop_now;
        end else begin
            if (push_m) m_sticky = m_sticky | f;
            if (drop_now) m_drop = 1'b1;
        end
        @(posedge CLK);
        #1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        check_state();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cycle(1'b0, 32'h0, 5'b0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_sticky   = '0;
        m_drop     = 1'b0;
        RST        = 1'b0;
        in_valid   = 1'b0;
        in_Sz      = 1'b0;
        in_Ez      = '0;
        in_Mz      = '0;
        in_flags   = '0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_sticky", 64'(sticky_flags), 64'd0);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Single push into an empty FIFO appears one cycle later
        cycle(1'b1, 32'h40000000, 5'b00000, 1'b0, 1'b0);
        check("lat1_data", 64'(out_data), 64'h40000000);
        check("lat1_count", 64'(count), 64'd1);
        drain();

        // Fill to full, then drop and accept-while-full
        cycle(1'b1, 32'h3F800000, 5'b00000, 1'b0, 1'b1);
        cycle(1'b1, 32'h40400000, 5'b00000, 1'b0, 1'b0);
        cycle(1'b1, 32'h7F800000, 5'b01010, 1'b0, 1'b0);
        check("afull_at_3", 64'(almost_full), 64'd1);
        cycle(1'b1, 32'h00000000, 5'b00001, 1'b0, 1'b0);
        check("full_at_4", 64'(full), 64'd1);
        check("sticky_01011", 64'(sticky_flags), 64'b01011);
        cycle(1'b1, 32'h41200000, 5'b00000, 1'b0, 1'b0);
        check("drop_set", 64'(drop_err), 64'd1);
        check("drop_count", 64'(count), 64'd4);
        cycle(1'b1, 32'h41200000, 5'b00000, 1'b1, 1'b0);
        check("full_accept_count", 64'(count), 64'd4);
        drain();

        // Streaming: pointers wrap more than twice
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h3F000000 + 32'(i * 3), 5'(i), 1'b1, 1'b0);
            check("stream_count", 64'(count), 64'd1);
        end
        drain();

        // Clear coinciding with a push keeps only the new flags
        cycle(1'b1, 32'hC0000000, 5'b10000, 1'b0, 1'b1);
        check("clr_sticky", 64'(sticky_flags), 64'b10000);
        check("clr_drop", 64'(drop_err), 64'd0);
        drain();

        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        end
        drain();

        // Asynchronous reset with three queued entries
        cycle(1'b1, 32'h11111111, 5'b00100, 1'b0, 1'b0);
        cycle(1'b1, 32'h22222222, 5'b00010, 1'b0, 1'b0);
        cycle(1'b1, 32'h33333333, 5'b10000, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_sticky", 64'(sticky_flags), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_full", 64'(full), 64'd0);
        sb.delete();
        m_sticky = '0;
        m_drop   = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cycle(1'b1, 32'h44444444, 5'b00001, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
